// File: rtl/harmonic_classifier.sv
// Per-frame waveform classifier: compares harmonic amplitude ratios with one shared
// multiplier, then debounces the result with an N-frame agreement filter.
module harmonic_classifier #(
  parameter logic [23:0] MIN_AMP    = 24'd1000,
  parameter logic [7:0]  SINE_DIV   = 8'd20,
  parameter logic [7:0]  TRI_SQ_DIV = 8'd5,
  parameter logic [7:0]  SQ5_DIV    = 8'd8,
  parameter logic [3:0]  STABLE_N   = 4'd3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        catch_flag,
  input  logic [23:0] amp_1,
  input  logic [23:0] amp_2,
  input  logic [23:0] amp_3,
  input  logic [23:0] amp_4,
  input  logic [23:0] amp_5,
  output logic [2:0]  raw_type,
  output logic        result_valid,
  output logic [2:0]  wave_type,
  output logic        type_stable
);

  typedef enum logic [2:0] {IDLE, CMP_MIN, CMP_SINE, CMP_SQ, CMP5, DECIDE} state_t;

  state_t      state, next_state;
  logic        catch_d;
  logic [23:0] a1, a2, a3, a4, a5;
  logic [2:0]  prev_class, cls;
  logic [3:0]  agree_cnt, new_cnt;
  logic [23:0] mul_a;
  logic [7:0]  mul_b;
  logic [31:0] product, a1_ext;
  logic        frame_end, prod_lt;
  logic        unused_reserved;

  assign frame_end = catch_d & ~catch_flag;
  assign product   = {8'd0, mul_a} * {24'd0, mul_b};
  assign a1_ext    = {8'd0, a1};
  assign prod_lt   = product < a1_ext;

  // a4/a5 are held for a future THD stage and intentionally feed nothing.
  assign unused_reserved = ^{a4, a5};

  assign new_cnt = (cls == prev_class)
                 ? ((agree_cnt >= STABLE_N) ? STABLE_N : agree_cnt + 4'd1)
                 : 4'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (frame_end) next_state = CMP_MIN;
      CMP_MIN:  next_state = (a1 < MIN_AMP) ? DECIDE : CMP_SINE;
      CMP_SINE: next_state = prod_lt ? DECIDE : CMP_SQ;
      CMP_SQ:   next_state = prod_lt ? DECIDE : CMP5;
      CMP5:     next_state = DECIDE;
      DECIDE:   next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // cls is only meaningful on the cycle that hands over to DECIDE.
  always_comb begin
    mul_a        = '0;
    mul_b        = '0;
    cls          = 3'd0;
    result_valid = (state == DECIDE);
    case (state)
      CMP_SINE: begin mul_a = a2; mul_b = SINE_DIV;   cls = 3'd1; end
      CMP_SQ:   begin mul_a = a2; mul_b = TRI_SQ_DIV; cls = 3'd2; end
      CMP5:     begin mul_a = a3; mul_b = SQ5_DIV;    cls = prod_lt ? 3'd4 : 3'd3; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      catch_d     <= 1'b0;
      a1          <= '0;
      a2          <= '0;
      a3          <= '0;
      a4          <= '0;
      a5          <= '0;
      raw_type    <= 3'd0;
      wave_type   <= 3'd0;
      type_stable <= 1'b0;
      prev_class  <= 3'd0;
      agree_cnt   <= 4'd0;
    end else begin
      catch_d <= catch_flag;
      if (state == IDLE && frame_end) begin
        a1 <= amp_1;
        a2 <= amp_2;
        a3 <= amp_3;
        a4 <= amp_4;
        a5 <= amp_5;
      end
      if (next_state == DECIDE) begin
        raw_type   <= cls;
        prev_class <= cls;
        agree_cnt  <= new_cnt;
        if (cls != prev_class) type_stable <= 1'b0;
        if (new_cnt == STABLE_N) begin
          wave_type   <= cls;
          type_stable <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_harmonic_classifier.sv
// Directed bench for harmonic_classifier: a ratio/history model predicts every output
// each cycle, and literal expectations pin individual frames.
module tb_harmonic_classifier;

  logic        clk = 1'b0;
  logic        rst_n, catch_flag;
  logic [23:0] amp_1, amp_2, amp_3, amp_4, amp_5;
  logic [2:0]  raw_type, wave_type;
  logic        result_valid, type_stable;

  harmonic_classifier dut (
    .clk(clk), .rst_n(rst_n), .catch_flag(catch_flag),
    .amp_1(amp_1), .amp_2(amp_2), .amp_3(amp_3), .amp_4(amp_4), .amp_5(amp_5),
    .raw_type(raw_type), .result_valid(result_valid),
    .wave_type(wave_type), .type_stable(type_stable)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit checking = 0;

  bit m_busy, m_catch_prev;
  int m_cnt, m_pend, m_raw, m_wave, m_stable, m_valid;
  int hist[$];

  function automatic int classify(longint x1, longint x2, longint x3);
    if (x1 < 1000) return 0;
    if (x2 * 20 < x1) return 1;
    if (x2 * 5 < x1) return 2;
    if (x3 * 8 >= x1) return 3;
    return 4;
  endfunction

  function automatic int latency(int c);
    case (c)
      0: return 2;
      1: return 3;
      2: return 4;
      default: return 5;
    endcase
  endfunction

  task automatic checkOutput(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Model: a frame resolves latency() cycles after its falling edge; the filter reports
  // a class once the trailing run of identical results reaches three.
  always @(posedge clk) begin
    bit was_busy;
    int run;
    cyc++;
    if (!rst_n) begin
      m_busy = 0; m_catch_prev = 0; m_cnt = 0; m_pend = 0;
      m_raw = 0; m_wave = 0; m_stable = 0; m_valid = 0;
      hist.delete();
    end else begin
      was_busy = m_busy;
      m_valid = 0;
      if (m_busy) begin
        if (m_cnt == 0) m_busy = 0;
        else begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_valid = 1;
            m_raw = m_pend;
            hist.push_back(m_pend);
            run = 0;
            for (int i = hist.size() - 1; i >= 0 && hist[i] == m_pend; i--) run++;
            if (run >= 3) begin
              m_wave = m_pend;
              m_stable = 1;
            end else m_stable = 0;
          end
        end
      end
      if (!was_busy && m_catch_prev && !catch_flag) begin
        m_pend = classify(longint'(amp_1), longint'(amp_2), longint'(amp_3));
        m_busy = 1;
        m_cnt = latency(m_pend) - 1;
      end
      m_catch_prev = catch_flag;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      checkOutput("result_valid", int'(result_valid), m_valid);
      checkOutput("raw_type", int'(raw_type), m_raw);
      checkOutput("wave_type", int'(wave_type), m_wave);
      checkOutput("type_stable", int'(type_stable), m_stable);
    end
  end

  task automatic applyStimulus(input int x1, input int x2, input int x3,
                               input int exp_cls, input int exp_lat);
    int fcyc;
    bit seen;
    @(posedge clk); #1;
    catch_flag = 1'b1;
    amp_1 = 24'(x1); amp_2 = 24'(x2); amp_3 = 24'(x3);
    amp_4 = 24'($urandom); amp_5 = 24'($urandom);
    @(posedge clk); #1;
    catch_flag = 1'b0;
    fcyc = cyc;
    @(posedge clk); #1;
    amp_1 = 24'($urandom); amp_2 = 24'($urandom); amp_3 = 24'($urandom);
    seen = 0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      if (result_valid) seen = 1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("[TB] FAIL pulse_timeout: got no result_valid, expected class %0d", exp_cls);
    end else begin
      checkOutput("raw_literal", int'(raw_type), exp_cls);
      checkOutput("latency_literal", cyc - fcyc, exp_lat);
    end
  endtask

  initial begin
    int pulses, pulse_raw;
    rst_n = 1'b0; catch_flag = 1'b0;
    amp_1 = '0; amp_2 = '0; amp_3 = '0; amp_4 = '0; amp_5 = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    checking = 1;
    checkOutput("reset_raw", int'(raw_type), 0);
    checkOutput("reset_wave", int'(wave_type), 0);
    checkOutput("reset_stable", int'(type_stable), 0);
    checkOutput("reset_valid", int'(result_valid), 0);

    $display("[TB] classification frames");
    applyStimulus(900, 0, 0, 0, 2);
    applyStimulus(1000, 0, 0, 1, 3);
    applyStimulus(100000, 4000, 0, 1, 3);
    applyStimulus(100000, 5000, 0, 2, 4);
    applyStimulus(100000, 11111, 4000, 2, 4);
    applyStimulus(100000, 33333, 20000, 3, 5);
    applyStimulus(100000, 33333, 5000, 4, 5);

    $display("[TB] agreement filter");
    repeat (3) applyStimulus(100000, 33333, 20000, 3, 5);
    checkOutput("filter_sq_wave", int'(wave_type), 3);
    checkOutput("filter_sq_stable", int'(type_stable), 1);
    applyStimulus(100000, 4000, 0, 1, 3);
    checkOutput("filter_change_wave", int'(wave_type), 3);
    checkOutput("filter_change_stable", int'(type_stable), 0);
    repeat (3) applyStimulus(100000, 4000, 0, 1, 3);
    checkOutput("filter_sine_wave", int'(wave_type), 1);
    checkOutput("filter_sine_stable", int'(type_stable), 1);

    $display("[TB] reset during CMP_SQ");
    @(posedge clk); #1;
    catch_flag = 1'b1; amp_1 = 24'd100000; amp_2 = 24'd33333; amp_3 = 24'd20000;
    @(posedge clk); #1;
    catch_flag = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkOutput("midreset_valid", int'(result_valid), 0);
    checkOutput("midreset_raw", int'(raw_type), 0);
    checkOutput("midreset_wave", int'(wave_type), 0);
    checkOutput("midreset_stable", int'(type_stable), 0);
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (result_valid) pulses++;
    end
    checkOutput("midreset_pulses", pulses, 0);

    $display("[TB] second frame end while busy");
    @(posedge clk); #1;
    catch_flag = 1'b1; amp_1 = 24'd100000; amp_2 = 24'd4000; amp_3 = 24'd0;
    @(posedge clk); #1;
    catch_flag = 1'b0;
    @(posedge clk); #1;
    catch_flag = 1'b1; amp_1 = 24'd900;
    @(posedge clk); #1;
    catch_flag = 1'b0;
    pulses = 0;
    pulse_raw = -1;
    repeat (10) begin
      @(negedge clk);
      if (result_valid) begin
        pulses++;
        pulse_raw = int'(raw_type);
      end
    end
    checkOutput("busy_pulses", pulses, 1);
    checkOutput("busy_raw", pulse_raw, 1);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/harmonic_classifier.md
Name: harmonic_classifier

Overview:
- Consumes the five harmonic amplitudes (fundamental, 3rd, 5th, 7th, 9th) and the capture flag from the FFT harmonic-capture stage.
- Once per FFT frame, it classifies the input waveform as none, sine, triangle, square or unknown, using ratio comparisons done with multiplies (no divider).
- It applies an N-frame agreement filter before updating the reported type.
- Output drives the display/report logic.

Parameters:
- MIN_AMP, 24'd1000: minimum fundamental amplitude for a valid signal.
- SINE_DIV, 8'd20: sine if amp_2*SINE_DIV < amp_1 (3rd harmonic below 5%).
- TRI_SQ_DIV, 8'd5: square candidate if amp_2*TRI_SQ_DIV >= amp_1 (3rd harmonic at or above 20%).
- SQ5_DIV, 8'd8: square confirmed if amp_3*SQ5_DIV >= amp_1 (5th harmonic at or above 12.5%).
- STABLE_N, 4'd3: consecutive identical raw results required to update wave_type.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- catch_flag  in  1  high while the capture stage is collecting; falling edge = amplitudes complete
- amp_1  in  24  fundamental amplitude
- amp_2  in  24  3rd harmonic amplitude
- amp_3  in  24  5th harmonic amplitude
- amp_4  in  24  7th harmonic amplitude (latched only, reserved)
- amp_5  in  24  9th harmonic amplitude (latched only, reserved)
- raw_type  out  3  per-frame classification: 0 none, 1 sine, 2 triangle, 3 square, 4 unknown
- result_valid  out  1  one-cycle pulse when raw_type is updated
- wave_type  out  3  filtered classification, same encoding
- type_stable  out  1  high while the last STABLE_N raw results agree with wave_type

Behaviour:
- Reset: rst_n is synchronous and active-low, sampled on the rising edge of clk.
  - All outputs reset to 0, FSM goes to IDLE, internal latches and counters clear.
  - Reset overrides any operation in progress; a partially evaluated frame is discarded with no result_valid.
- Frame detect:
  - catch_d is the registered copy of catch_flag.
  - Frame end F is the cycle in which catch_d=1 and catch_flag=0.
  - In IDLE at cycle F, amp_1..amp_5 are latched into a1..a5 and the FSM enters CMP_MIN.
  - A frame end occurring while the FSM is not in IDLE is ignored; the latches are not overwritten.
- Arithmetic:
  - A single shared 24x8 unsigned multiplier produces a 32-bit product.
  - The product is compared against a1 zero-extended to 32 bits.
  - One comparison per cycle; no overflow is possible.
- FSM, one state per cycle:
  - IDLE: waits for frame end.
  - CMP_MIN: a1 < MIN_AMP -> class 0, go to DECIDE.
  - CMP_SINE: a2*SINE_DIV < a1 (strict) -> class 1, go to DECIDE.
  - CMP_SQ: a2*TRI_SQ_DIV >= a1 -> go to CMP5; otherwise class 2, go to DECIDE.
  - CMP5: a3*SQ5_DIV >= a1 -> class 3, otherwise class 4; go to DECIDE.
  - DECIDE: raw_type <= class, result_valid <= 1 for one cycle, filter update, return to IDLE.
- Latency:
  - Early-exit paths skip the remaining compare states.
  - result_valid is high in cycle F+2 (none), F+3 (sine), F+4 (triangle) or F+5 (square/unknown).
  - raw_type holds its value between pulses.
- Filter, updated only at the DECIDE step:
  - If class == previous class, agree_cnt increments, saturating at STABLE_N; otherwise agree_cnt resets to 1.
  - When agree_cnt reaches STABLE_N, wave_type <= class and type_stable <= 1 in the same cycle.
  - On a class change, type_stable <= 0 and wave_type holds its old value.
  - The "previous class" register starts at 0 after reset.
- a4 and a5 are latched but unused; they are reserved for a future THD extension and must not affect the outputs.

Test Plan:
- Reset, then a frame with amp_1=900 -> raw_type=0, result_valid 2 cycles after frame end; amp_1=1000 exactly -> not class 0.
- amp_1=100000, amp_2=4000 -> raw_type=1 (80000<100000); amp_2=5000 -> not sine (equality fails the strict compare).
- amp_1=100000, amp_2=11111, amp_3=4000 -> raw_type=2, result_valid at F+4.
- amp_1=100000, amp_2=33333, amp_3=20000 -> raw_type=3; same frame with amp_3=5000 -> raw_type=4 (40000<100000), both at F+5.
- Filter: three square frames -> wave_type=3, type_stable=1 on the third pulse; then one sine frame -> type_stable=0, wave_type stays 3; then three sine frames -> wave_type=1.
- Reset asserted in CMP_SQ -> no result_valid pulse, all outputs 0 next cycle; a second frame end injected during CMP_SINE -> ignored, only one pulse.
